// File: rtl/uart_tx_core.sv
// uart_tx_core: parametrised UART transmitter.
// Frame: start bit, DATA_WIDTH data bits (LSB first), optional parity, 1 or 2 stop bits.
// Every bit lasts PRESCALE clocks; a PRESCALE of 0 behaves like 1.
// TX_OUT, BUSY and DATA_ACK are all registered.
module uart_tx_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      DATA_ACK
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state_r;
  logic [PRESCALE_WIDTH-1:0] cnt_r;       // position inside the current bit period
  logic [PRESCALE_WIDTH-1:0] last_cnt_r;  // N-1 for this frame
  logic [BIT_W-1:0]          bit_idx_r;
  logic [DATA_WIDTH-1:0]     shift_r;     // remaining data bits, next one in bit 0
  logic                      parity_r;
  logic                      par_en_r;
  logic                      stop2_r;
  logic                      stop_cnt_r;  // 1 while sending the second stop bit

  // Parity bit: even parity is the XOR of the data; odd parity inverts it.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Frame controller, serializer and output registers in one state machine.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      last_cnt_r <= '0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
      parity_r   <= 1'b0;
      par_en_r   <= 1'b0;
      stop2_r    <= 1'b0;
      stop_cnt_r <= 1'b0;
      TX_OUT     <= 1'b1;
      BUSY       <= 1'b0;
      DATA_ACK   <= 1'b0;
    end else begin
      DATA_ACK <= 1'b0;
      case (state_r)
        IDLE: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          if (DATA_VALID) begin
            // Freeze the whole frame configuration at acceptance.
            shift_r    <= P_DATA;
            parity_r   <= calc_parity(P_DATA, PAR_TYP);
            par_en_r   <= PAR_EN;
            stop2_r    <= STOP2;
            last_cnt_r <= (PRESCALE == '0) ? '0 : (PRESCALE - PRESCALE_WIDTH'(1));
            cnt_r      <= '0;
            bit_idx_r  <= '0;
            stop_cnt_r <= 1'b0;
            TX_OUT     <= 1'b0;
            BUSY       <= 1'b1;
            DATA_ACK   <= 1'b1;
            state_r    <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == last_cnt_r) begin
            cnt_r     <= '0;
            bit_idx_r <= '0;
            TX_OUT    <= shift_r[0];
            shift_r   <= shift_r >> 1;
            state_r   <= DATA;
          end else begin
            cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
          end
        end
        DATA: begin
          if (cnt_r == last_cnt_r) begin
            cnt_r <= '0;
            if (bit_idx_r == LAST_BIT) begin
              if (par_en_r) begin
                TX_OUT  <= parity_r;
                state_r <= PARITY;
              end else begin
                TX_OUT     <= 1'b1;
                stop_cnt_r <= 1'b0;
                state_r    <= STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + BIT_W'(1);
              TX_OUT    <= shift_r[0];
              shift_r   <= shift_r >> 1;
            end
          end else begin
            cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
          end
        end
        PARITY: begin
          if (cnt_r == last_cnt_r) begin
            cnt_r      <= '0;
            TX_OUT     <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= STOP;
          end else begin
            cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
          end
        end
        STOP: begin
          if (cnt_r == last_cnt_r) begin
            cnt_r <= '0;
            if (stop2_r && !stop_cnt_r) begin
              stop_cnt_r <= 1'b1;
            end else begin
              TX_OUT  <= 1'b1;
              BUSY    <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
          end
        end
        default: begin
          TX_OUT  <= 1'b1;
          BUSY    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core: an 8-bit and a 5-bit instance.
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] p8   = 8'h00;
  logic       dv8  = 1'b0;
  logic       pe8  = 1'b0;
  logic       pt8  = 1'b0;
  logic       st8  = 1'b0;
  logic [5:0] pre8 = 6'd1;
  logic       tx8, busy8, ack8;

  logic [4:0] p5   = 5'd0;
  logic       dv5  = 1'b0;
  logic       pe5  = 1'b0;
  logic       pt5  = 1'b0;
  logic       st5  = 1'b0;
  logic [5:0] pre5 = 6'd1;
  logic       tx5, busy5, ack5;

  int total = 0;
  int fails = 0;

  uart_tx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(p8), .DATA_VALID(dv8), .PAR_EN(pe8),
    .PAR_TYP(pt8), .STOP2(st8), .PRESCALE(pre8),
    .TX_OUT(tx8), .BUSY(busy8), .DATA_ACK(ack8)
  );

  uart_tx_core #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(p5), .DATA_VALID(dv5), .PAR_EN(pe5),
    .PAR_TYP(pt5), .STOP2(st5), .PRESCALE(pre5),
    .TX_OUT(tx5), .BUSY(busy5), .DATA_ACK(ack5)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Accepts a frame at the next edge (DATA_VALID already high) and checks every
  // clock of it. exp_bits[i] is the i-th serial bit; each lasts n clocks.
  task automatic run_frame(input int sel, input logic [15:0] exp_bits, input int nbits,
                           input int n, input logic hold, input logic disturb,
                           input string tag);
    logic tx, busy, ack;
    tick();
    ack  = (sel == 5) ? ack5 : ack8;
    busy = (sel == 5) ? busy5 : busy8;
    check({tag, "_ack_first"}, ack, 1'b1);
    check({tag, "_busy_first"}, busy, 1'b1);
    if (!hold) begin
      if (sel == 5) dv5 = 1'b0; else dv8 = 1'b0;
    end
    for (int i = 0; i < nbits * n; i++) begin
      tx   = (sel == 5) ? tx5 : tx8;
      busy = (sel == 5) ? busy5 : busy8;
      ack  = (sel == 5) ? ack5 : ack8;
      check($sformatf("%s_tx_%0d", tag, i), tx, exp_bits[i / n]);
      check($sformatf("%s_busy_%0d", tag, i), busy, 1'b1);
      if (i >= 1) check($sformatf("%s_ack_%0d", tag, i), ack, 1'b0);
      if (disturb && i == 5) begin
        dv8  = 1'b1;
        p8   = 8'h3C;
        pre8 = 6'd7;
      end
      if (disturb && i == 6) dv8 = 1'b0;
      tick();
    end
    tx   = (sel == 5) ? tx5 : tx8;
    busy = (sel == 5) ? busy5 : busy8;
    ack  = (sel == 5) ? ack5 : ack8;
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_tx"}, tx, 1'b1);
    check({tag, "_end_ack"}, ack, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_tx8", tx8, 1'b1);
    check("rst_busy8", busy8, 1'b0);
    check("rst_ack8", ack8, 1'b0);
    check("rst_tx5", tx5, 1'b1);
    check("rst_busy5", busy5, 1'b0);
    rst = 1'b1;
    tick();

    // Basic frame: 0xA5, no parity, one stop, N=1
    p8 = 8'hA5; pe8 = 1'b0; st8 = 1'b0; pre8 = 6'd1; dv8 = 1'b1;
    run_frame(8, 16'h034A, 10, 1, 1'b0, 1'b0, "basic");
    tick();

    // Odd parity, two stops, N=4 (48 clocks)
    p8 = 8'hA5; pe8 = 1'b1; pt8 = 1'b1; st8 = 1'b1; pre8 = 6'd4; dv8 = 1'b1;
    run_frame(8, 16'h0F4A, 12, 4, 1'b0, 1'b0, "par_odd");
    tick();

    // Even parity variant
    pt8 = 1'b0; dv8 = 1'b1;
    run_frame(8, 16'h0D4A, 12, 4, 1'b0, 1'b0, "par_even");
    tick();

    // Back-to-back with DATA_VALID held: 0x00 then 0xFF, N=2
    p8 = 8'h00; pe8 = 1'b0; st8 = 1'b0; pre8 = 6'd2; dv8 = 1'b1;
    run_frame(8, 16'h0200, 10, 2, 1'b1, 1'b0, "b2b_first");
    p8 = 8'hFF;
    run_frame(8, 16'h03FE, 10, 2, 1'b0, 1'b0, "b2b_second");
    tick();

    // Ignored inputs during a frame
    p8 = 8'hA5; pre8 = 6'd2; dv8 = 1'b1;
    run_frame(8, 16'h034A, 10, 2, 1'b0, 1'b1, "ignored");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ignored_idle_busy_%0d", i), busy8, 1'b0);
      check($sformatf("ignored_idle_tx_%0d", i), tx8, 1'b1);
      check($sformatf("ignored_idle_ack_%0d", i), ack8, 1'b0);
    end

    // Reset during data bit 3 (0xA5 bit 3 is 0)
    p8 = 8'hA5; pre8 = 6'd2; dv8 = 1'b1;
    tick();
    check("midrst_ack", ack8, 1'b1);
    dv8 = 1'b0;
    repeat (8) tick();
    check("midrst_bit3_tx", tx8, 1'b0);
    check("midrst_bit3_busy", busy8, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_tx", tx8, 1'b1);
    check("midrst_busy", busy8, 1'b0);
    check("midrst_ack0", ack8, 1'b0);
    tick();
    check("midrst_hold_tx", tx8, 1'b1);
    rst = 1'b1;
    tick();
    check("postrst_idle_busy", busy8, 1'b0);
    p8 = 8'h5A; pre8 = 6'd1; dv8 = 1'b1;
    run_frame(8, 16'h02B4, 10, 1, 1'b0, 1'b0, "postrst");
    tick();

    // 5-bit instance, PRESCALE=0, even parity
    p5 = 5'b10011; pre5 = 6'd0; pe5 = 1'b1; pt5 = 1'b0; st5 = 1'b0; dv5 = 1'b1;
    run_frame(5, 16'h00E6, 8, 1, 1'b0, 1'b0, "w5");
    tick();
    check("w5_idle_tx", tx5, 1'b1);
    check("w5_idle_busy", busy5, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter combining the frame controller, serializer, parity generator and output multiplexer in one block. It adds configurable data width, odd/even parity, one or two stop bits, and a programmable per-bit clock prescale. It sits between the system-side parallel data source and the serial TX pin, replacing the fixed 8-bit, one-clock-per-bit transmit path.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- PRESCALE_WIDTH, 6, width of the PRESCALE input.

- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  in  1  request to send P_DATA; sampled only in IDLE.
- PAR_EN  in  1  1 = insert a parity bit after the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- PRESCALE  in  PRESCALE_WIDTH  clocks per bit (N); value 0 is treated as 1.
- TX_OUT  out  1  serial line, registered; idles high.
- BUSY  out  1  registered; high while a frame is in progress.
- DATA_ACK  out  1  registered one-cycle pulse when a word is accepted.

## Operation
- Reset values: TX_OUT=1, BUSY=0, DATA_ACK=0, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. DATA_VALID=1 at a clock edge captures P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE into internal registers and moves the block to START.
- START: TX_OUT=0 for N clocks, then moves to DATA.
- DATA: sends the captured bits LSB first, each for N clocks. A bit index runs from 0 to DATA_WIDTH-1. After the last bit, moves to PARITY if the captured PAR_EN=1, otherwise to STOP.
- PARITY: sends the XOR-reduction of the captured data for even parity, or its inverse for odd parity, for N clocks.
- STOP: TX_OUT=1 for N clocks, or for 2N clocks if the captured STOP2=1, then moves to IDLE.
- Bit-period counter: counts 0..N-1 and advances the bit or state at N-1. It is PRESCALE_WIDTH bits wide, so the maximum N is 2^PRESCALE_WIDTH-1.
- Captured configuration is frozen for the whole frame. Changes on P_DATA, PAR_*, STOP2 and PRESCALE during BUSY have no effect.
- DATA_VALID while BUSY=1 is ignored. It is not queued, and there is no DATA_ACK.
- DATA_VALID held high continuously sends back-to-back frames, each acknowledged once.
- Reset mid-frame: asynchronously forces TX_OUT=1, BUSY=0, DATA_ACK=0 and IDLE. The partial frame is abandoned.

## Timing
- Acceptance edge k (IDLE, DATA_VALID=1): from edge k, TX_OUT=0, BUSY=1 and DATA_ACK=1. DATA_ACK drops at edge k+1.
- Latency from the request edge to the start bit on TX_OUT is 0 extra cycles, because TX_OUT is registered at edge k.
- Frame length L = N × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) clocks. BUSY is high for exactly L clocks.
- At edge k+L the block is back in IDLE with TX_OUT=1 and BUSY=0. The earliest next acceptance is edge k+L+1, so back-to-back frames have a one-clock idle gap.
- TX_OUT never glitches; it changes only on clock edges or on reset assertion.

## Test plan
- Basic frame: DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, STOP2=0, PRESCALE=1, one DATA_VALID pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 at one bit per clock. BUSY is high for 10 clocks. There is one DATA_ACK pulse coincident with the start bit.
- Parity and prescale: P_DATA=0xA5, PAR_EN=1, PAR_TYP=1, STOP2=1, PRESCALE=4 -> parity bit 1, each bit held 4 clocks, BUSY high for 48 clocks. Repeat with PAR_TYP=0 -> parity bit 0.
- Back-to-back: DATA_VALID held high, with P_DATA=0x00 for the first frame and then 0xFF, PRESCALE=2 -> two 20-clock frames separated by exactly one idle clock with TX_OUT=1. There are two DATA_ACK pulses, and each frame carries its own data.
- Ignored inputs: during a frame, pulse DATA_VALID, change P_DATA to 0x3C and change PRESCALE to 7 -> the frame is unchanged, there is no extra DATA_ACK, and no second frame is sent.
- Reset mid-frame: assert RST during data bit 3 -> TX_OUT=1 and BUSY=0 immediately. After release, a new 0x5A frame transmits correctly from its start bit.
- Width and zero prescale: DATA_WIDTH=5 instance, P_DATA=5'b10011, PRESCALE=0, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,1,0,0,1,1,1 at one clock per bit. BUSY is high for 8 clocks.
